digital_port_arbiter: RTL and testbench

Two-requester round-robin controller that shares one DigitalPort instance between a CPU-side bus master and a secondary master such as a DMA or pattern engine. It converts per-requester transactions (read IO, write IO, write direction, read direction) into the port's single-cycle chipSelect/writeIO/writeDirection strobes. It then returns completion and read data to the granted requester. It sits between the bus fabric and DigitalPort; the port's own registers are untouched.

---
 rtl/digital_port_pkg.sv | 25 ++
 rtl/digital_port_arbiter_if.sv | 46 ++++
 rtl/digital_port_arbiter_rr_arbiter2.sv | 36 +++
 rtl/digital_port_arbiter.sv | 153 +++++++++++++++
 tb/tb_digital_port_arbiter.sv | 272 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/digital_port_pkg.sv
// Shared types and constants for the DigitalPort round-robin arbiter.
// The operation codes match the requester op bus encoding.
package digital_port_pkg;

  localparam int DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    READ_IO   = 2'b00,
    WRITE_IO  = 2'b01,
    WRITE_DIR = 2'b10,
    READ_DIR  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ISSUE  = 2'b01,
    SAMPLE = 2'b10,
    DONE   = 2'b11
  } state_e;

  function automatic logic op_is_read(input op_e op);
    return (op == READ_IO) || (op == READ_DIR);
  endfunction

endpackage

// File: rtl/digital_port_arbiter_if.sv
// Bundles both requester channels and the DigitalPort strobe/data pins.
// The slave modport is the arbiter; the master modport is the requesters and the port.
interface digital_port_arbiter_if #(
  parameter int DATA_WIDTH = digital_port_pkg::DATA_WIDTH
);

  logic                  req0_valid;
  logic [1:0]            req0_op;
  logic [DATA_WIDTH-1:0] req0_data;
  logic                  req0_ready;
  logic                  req0_rvalid;
  logic [DATA_WIDTH-1:0] req0_rdata;

  logic                  req1_valid;
  logic [1:0]            req1_op;
  logic [DATA_WIDTH-1:0] req1_data;
  logic                  req1_ready;
  logic                  req1_rvalid;
  logic [DATA_WIDTH-1:0] req1_rdata;

  logic                  port_cs;
  logic                  port_write_io;
  logic                  port_write_dir;
  logic [DATA_WIDTH-1:0] port_data_in;
  logic [DATA_WIDTH-1:0] port_data_out;
  logic [DATA_WIDTH-1:0] port_dir_out;

  modport master (
    output req0_valid, req0_op, req0_data,
    input  req0_ready, req0_rvalid, req0_rdata,
    output req1_valid, req1_op, req1_data,
    input  req1_ready, req1_rvalid, req1_rdata,
    input  port_cs, port_write_io, port_write_dir, port_data_in,
    output port_data_out, port_dir_out
  );

  modport slave (
    input  req0_valid, req0_op, req0_data,
    output req0_ready, req0_rvalid, req0_rdata,
    input  req1_valid, req1_op, req1_data,
    output req1_ready, req1_rvalid, req1_rdata,
    output port_cs, port_write_io, port_write_dir, port_data_in,
    input  port_data_out, port_dir_out
  );

endinterface

// File: rtl/digital_port_arbiter_rr_arbiter2.sv
// Two-way round-robin arbiter: combinational one-hot grant, pointer moves
// to the non-granted requester whenever a grant is accepted.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant
);

  // ptr_r set means req1 wins a tie
  logic ptr_r;

  // Pick the winner among the valid requesters
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr_r ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

  // Priority pointer register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r <= 1'b0;
    end else if (advance) begin
      ptr_r <= grant[0];
    end else begin
      ptr_r <= ptr_r;
    end
  end

endmodule

// File: rtl/digital_port_arbiter.sv
// Shares one DigitalPort between two requesters: accepts one transaction at a
// time, drives the port strobes and returns completion/read data to the winner.
module digital_port_arbiter
  import digital_port_pkg::*;
#(
  parameter int DATA_WIDTH = digital_port_pkg::DATA_WIDTH
) (
  input logic                  clk,
  input logic                  reset,
  digital_port_arbiter_if.slave bus
);

  state_e                state_r, state_next_s;
  logic                  grant_sel_r, grant_sel_next_s;
  op_e                   op_r, op_next_s;
  logic [DATA_WIDTH-1:0] data_r, data_next_s;
  logic [1:0]            ready_r, ready_next_s;
  logic [1:0]            rvalid_r, rvalid_next_s;
  logic [DATA_WIDTH-1:0] rdata0_r, rdata0_next_s;
  logic [DATA_WIDTH-1:0] rdata1_r, rdata1_next_s;
  logic                  cs_r, cs_next_s;
  logic                  write_io_r, write_io_next_s;
  logic                  write_dir_r, write_dir_next_s;
  logic [DATA_WIDTH-1:0] data_in_r, data_in_next_s;
  logic [DATA_WIDTH-1:0] result_s;
  logic [1:0]            valid_s;
  logic [1:0]            grant_s;
  logic                  advance_s;

  assign valid_s   = {bus.req1_valid, bus.req0_valid};
  assign advance_s = (state_r == IDLE) && (valid_s != 2'b00);

  rr_arbiter2 u_rr (
    .clk     (clk),
    .reset   (reset),
    .valid   (valid_s),
    .advance (advance_s),
    .grant   (grant_s)
  );

  // Outputs are registered one cycle behind the state that produces them,
  // so ready/strobe/rvalid land at T, T+1 and T+2 (T+3 for reads).
  always_comb begin
    state_next_s     = state_r;
    grant_sel_next_s = grant_sel_r;
    op_next_s        = op_r;
    data_next_s      = data_r;
    ready_next_s     = 2'b00;
    rvalid_next_s    = 2'b00;
    rdata0_next_s    = rdata0_r;
    rdata1_next_s    = rdata1_r;
    cs_next_s        = 1'b0;
    write_io_next_s  = 1'b0;
    write_dir_next_s = 1'b0;
    data_in_next_s   = {DATA_WIDTH{1'b0}};
    result_s         = data_r;
    case (state_r)
      IDLE: begin
        if (advance_s) begin
          ready_next_s     = grant_s;
          grant_sel_next_s = grant_s[1];
          if (grant_s[1]) begin
            op_next_s   = op_e'(bus.req1_op);
            data_next_s = bus.req1_data;
          end else begin
            op_next_s   = op_e'(bus.req0_op);
            data_next_s = bus.req0_data;
          end
          state_next_s = ISSUE;
        end else begin
          state_next_s = IDLE;
        end
      end
      ISSUE: begin
        cs_next_s        = 1'b1;
        data_in_next_s   = data_r;
        write_io_next_s  = (op_r == WRITE_IO);
        write_dir_next_s = (op_r == WRITE_DIR);
        if (op_is_read(op_r)) begin
          state_next_s = SAMPLE;
        end else begin
          state_next_s = DONE;
        end
      end
      SAMPLE: begin
        cs_next_s      = 1'b1;
        data_in_next_s = data_r;
        state_next_s   = DONE;
      end
      DONE: begin
        case (op_r)
          READ_IO:  result_s = bus.port_data_out;
          READ_DIR: result_s = bus.port_dir_out;
          default:  result_s = data_r;
        endcase
        if (grant_sel_r) begin
          rvalid_next_s = 2'b10;
          rdata1_next_s = result_s;
        end else begin
          rvalid_next_s = 2'b01;
          rdata0_next_s = result_s;
        end
        state_next_s = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // State, transaction latches and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      grant_sel_r <= 1'b0;
      op_r        <= READ_IO;
      data_r      <= {DATA_WIDTH{1'b0}};
      ready_r     <= 2'b00;
      rvalid_r    <= 2'b00;
      rdata0_r    <= {DATA_WIDTH{1'b0}};
      rdata1_r    <= {DATA_WIDTH{1'b0}};
      cs_r        <= 1'b0;
      write_io_r  <= 1'b0;
      write_dir_r <= 1'b0;
      data_in_r   <= {DATA_WIDTH{1'b0}};
    end else begin
      state_r     <= state_next_s;
      grant_sel_r <= grant_sel_next_s;
      op_r        <= op_next_s;
      data_r      <= data_next_s;
      ready_r     <= ready_next_s;
      rvalid_r    <= rvalid_next_s;
      rdata0_r    <= rdata0_next_s;
      rdata1_r    <= rdata1_next_s;
      cs_r        <= cs_next_s;
      write_io_r  <= write_io_next_s;
      write_dir_r <= write_dir_next_s;
      data_in_r   <= data_in_next_s;
    end
  end

  assign bus.req0_ready     = ready_r[0];
  assign bus.req1_ready     = ready_r[1];
  assign bus.req0_rvalid    = rvalid_r[0];
  assign bus.req1_rvalid    = rvalid_r[1];
  assign bus.req0_rdata     = rdata0_r;
  assign bus.req1_rdata     = rdata1_r;
  assign bus.port_cs        = cs_r;
  assign bus.port_write_io  = write_io_r;
  assign bus.port_write_dir = write_dir_r;
  assign bus.port_data_in   = data_in_r;

endmodule

// File: tb/tb_digital_port_arbiter.sv
// Directed and randomized checks of digital_port_arbiter against a
// transaction-level model of the arbitration, latency and port registers.
module tb_digital_port_arbiter;

  localparam int DW = 32;
  localparam logic [1:0] OP_RIO  = 2'b00;
  localparam logic [1:0] OP_WIO  = 2'b01;
  localparam logic [1:0] OP_WDIR = 2'b10;
  localparam logic [1:0] OP_RDIR = 2'b11;

  logic clk = 1'b0;
  logic reset;
  int   vectors = 0;
  int   miscompares = 0;

  // DigitalPort stand-in (never reset) and the reference model state
  logic [31:0] port_io = 32'h0;
  logic [31:0] port_dir = 32'h0;
  logic        io_force = 1'b0;
  logic [31:0] io_force_val = 32'h0;
  logic [31:0] ref_io = 32'h0;
  logic [31:0] ref_dir = 32'h0;
  logic [31:0] last_rdata [2];
  int          ptr_m = 0;
  logic [1:0]  op_m [2];
  logic [31:0] d_m [2];
  bit          pending [2];

  digital_port_arbiter_if #(.DATA_WIDTH(DW)) bus ();

  digital_port_arbiter #(.DATA_WIDTH(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.port_cs && bus.port_write_io)  port_io  <= bus.port_data_in;
    if (bus.port_cs && bus.port_write_dir) port_dir <= bus.port_data_in;
  end

  assign bus.port_data_out = io_force ? io_force_val : port_io;
  assign bus.port_dir_out  = port_dir;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int n);
    return (n == 0) ? bus.req0_ready : bus.req1_ready;
  endfunction

  function automatic logic get_rvalid(input int n);
    return (n == 0) ? bus.req0_rvalid : bus.req1_rvalid;
  endfunction

  function automatic logic [31:0] get_rdata(input int n);
    return (n == 0) ? bus.req0_rdata : bus.req1_rdata;
  endfunction

  task automatic set_req(input int n, input logic [1:0] op, input logic [31:0] d);
    op_m[n] = op;
    d_m[n]  = d;
    pending[n] = 1'b1;
    if (n == 0) begin
      bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_data = d;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_data = d;
    end
  endtask

  task automatic drop_req(input int n);
    pending[n] = 1'b0;
    if (n == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_outs"}, {bus.req0_ready, bus.req1_ready, bus.req0_rvalid, bus.req1_rvalid,
                        bus.port_cs, bus.port_write_io, bus.port_write_dir}, 32'h0);
    chk({tag, "_rdata0"}, bus.req0_rdata, 32'h0);
    chk({tag, "_rdata1"}, bus.req1_rdata, 32'h0);
    chk({tag, "_pdin"}, bus.port_data_in, 32'h0);
  endtask

  task automatic wait_ready(output int who);
    who = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.req0_ready) begin who = 0; break; end
      if (bus.req1_ready) begin who = 1; break; end
    end
    vectors++;
    assert (who >= 0) else begin
      miscompares++;
      $error("FAIL ready_timeout observed=none expected=ready within 20 cycles");
    end
  endtask

  // Called in the cycle where requester n shows ready; checks every cycle to rvalid
  task automatic follow(input int n, input logic [1:0] op, input logic [31:0] d);
    int o;
    bit rd;
    logic [31:0] exp;
    o  = 1 - n;
    rd = (op == OP_RIO) || (op == OP_RDIR);
    if (op == OP_RIO)       exp = io_force ? io_force_val : ref_io;
    else if (op == OP_RDIR) exp = ref_dir;
    else                    exp = d;
    ptr_m = o;
    chk("acc_ready_other", get_ready(o), 1'b0);
    chk("acc_cs", {bus.port_cs, bus.port_write_io, bus.port_write_dir}, 32'h0);
    @(negedge clk);
    chk("t1_cs", bus.port_cs, 1'b1);
    chk("t1_wio", bus.port_write_io, op == OP_WIO);
    chk("t1_wdir", bus.port_write_dir, op == OP_WDIR);
    chk("t1_pdin", bus.port_data_in, d);
    chk("t1_ready", {bus.req0_ready, bus.req1_ready}, 32'h0);
    chk("t1_rvalid", {bus.req0_rvalid, bus.req1_rvalid}, 32'h0);
    chk("t1_other_rdata", get_rdata(o), last_rdata[o]);
    if (rd) begin
      @(negedge clk);
      chk("t2_cs", bus.port_cs, 1'b1);
      chk("t2_strobes", {bus.port_write_io, bus.port_write_dir}, 32'h0);
      chk("t2_pdin", bus.port_data_in, d);
      chk("t2_rvalid", {bus.req0_rvalid, bus.req1_rvalid}, 32'h0);
    end
    @(negedge clk);
    chk("done_rvalid", get_rvalid(n), 1'b1);
    chk("done_rdata", get_rdata(n), exp);
    chk("done_other_rvalid", get_rvalid(o), 1'b0);
    chk("done_other_rdata", get_rdata(o), last_rdata[o]);
    chk("done_port_idle", {bus.port_cs, bus.port_write_io, bus.port_write_dir}, 32'h0);
    chk("done_pdin", bus.port_data_in, 32'h0);
    last_rdata[n] = exp;
    if (op == OP_WIO)  ref_io  = d;
    if (op == OP_WDIR) ref_dir = d;
  endtask

  task automatic run_txn(input int n, input logic [1:0] op, input logic [31:0] d);
    int who;
    @(negedge clk);
    set_req(n, op, d);
    wait_ready(who);
    chk("single_grant", who, n);
    if (who == n) begin
      drop_req(n);
      follow(n, op, d);
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    drop_req(0);
    drop_req(1);
    repeat (2) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b1;
    ptr_m = 0;
    last_rdata[0] = 32'h0;
    last_rdata[1] = 32'h0;
  endtask

  initial begin
    int who, exp_w;
    reset = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_op = 2'b00; bus.req0_data = 32'h0;
    bus.req1_valid = 1'b0; bus.req1_op = 2'b00; bus.req1_data = 32'h0;
    pending[0] = 1'b0; pending[1] = 1'b0;
    apply_reset();

    // Directed: writes, forced IO read, direction readback
    run_txn(0, OP_WDIR, 32'hFF00FF00);
    run_txn(1, OP_WIO, 32'hFFFFFFFF);
    io_force = 1'b1; io_force_val = 32'h12345678;
    run_txn(1, OP_RIO, 32'h0);
    io_force = 1'b0;
    run_txn(0, OP_WDIR, 32'h0000FFFF);
    run_txn(1, OP_RDIR, 32'hDEADBEEF);

    // Continuous contention after reset alternates req0, req1, req0, req1
    apply_reset();
    set_req(0, 2'($urandom_range(0, 3)), $urandom);
    set_req(1, 2'($urandom_range(0, 3)), $urandom);
    for (int k = 0; k < 4; k++) begin
      wait_ready(who);
      chk("rr_order", who, k % 2);
      if (who < 0) break;
      bus.req0_valid = bus.req0_valid;
      if (who == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
      pending[who] = 1'b0;
      follow(who, op_m[who], d_m[who]);
      if (k < 2) set_req(who, 2'($urandom_range(0, 3)), $urandom);
    end

    // Reset asserted while a WRITE_IO strobe is on the port
    @(negedge clk);
    set_req(0, OP_WIO, 32'hA5A55A5A);
    wait_ready(who);
    chk("abort_grant", who, 0);
    drop_req(0);
    @(negedge clk);
    chk("abort_strobe_seen", {bus.port_cs, bus.port_write_io}, 32'h3);
    #2 reset = 1'b0;
    #1 check_all_zero("async_reset");
    set_req(0, OP_WDIR, 32'h00C0FFEE);
    set_req(1, OP_WDIR, 32'h0BADCAFE);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_rvalid", {bus.req0_rvalid, bus.req1_rvalid, bus.req0_ready, bus.req1_ready}, 32'h0);
    end
    reset = 1'b1;
    ptr_m = 0;
    last_rdata[0] = 32'h0;
    last_rdata[1] = 32'h0;
    wait_ready(who);
    chk("post_reset_req0_first", who, 0);
    if (who == 0) begin drop_req(0); follow(0, OP_WDIR, 32'h00C0FFEE); end
    wait_ready(who);
    chk("post_reset_req1_next", who, 1);
    if (who == 1) begin drop_req(1); follow(1, OP_WDIR, 32'h0BADCAFE); end
    run_txn(0, OP_RIO, 32'h0);

    // req0 switches WRITE_IO -> READ_IO while waiting behind req1
    @(negedge clk);
    set_req(1, OP_RIO, 32'h0);
    wait_ready(who);
    chk("opchg_first", who, 1);
    if (who == 1) begin
      drop_req(1);
      set_req(0, OP_WIO, 32'h0BAD0BAD);
      follow(1, OP_RIO, 32'h0);
      set_req(0, OP_RIO, 32'h0BAD0BAD);
      wait_ready(who);
      chk("opchg_second", who, 0);
      if (who == 0) begin drop_req(0); follow(0, OP_RIO, 32'h0BAD0BAD); end
    end
    run_txn(1, OP_RIO, 32'h0);

    // Randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      if (!pending[0] && !pending[1]) repeat ($urandom_range(0, 2)) @(negedge clk);
      for (int n = 0; n < 2; n++)
        if (!pending[n] && $urandom_range(0, 1) == 1) set_req(n, 2'($urandom_range(0, 3)), $urandom);
      if (!pending[0] && !pending[1]) set_req($urandom_range(0, 1), 2'($urandom_range(0, 3)), $urandom);
      for (int n = 0; n < 2; n++)
        if (pending[n] && $urandom_range(0, 3) == 0) set_req(n, 2'($urandom_range(0, 3)), d_m[n]);
      exp_w = (pending[0] && pending[1]) ? ptr_m : (pending[0] ? 0 : 1);
      wait_ready(who);
      chk("rand_grant", who, exp_w);
      if (who < 0) break;
      drop_req(who);
      follow(who, op_m[who], d_m[who]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=still running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
